// File: rtl/sr_pole_pred.sv
// sr_pole_pred: SR1/SR2 delay line and pole predictor SPOLE = A1*SR1 + A2*SR2.
// Optional macro SR_POLE_SAT_EN saturates SPOLE instead of wrapping.
module sr_pole_pred #(
  parameter logic [10:0] SR_RST = 11'h020
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STB,
  input  logic [10:0] SR0,
  input  logic [15:0] A1,
  input  logic [15:0] A2,
  output logic [15:0] SPOLE,
  output logic        DONE,
  output logic        BUSY,
  output logic        OVR
);

  typedef enum logic [1:0] {
    IDLE, MUL1, MUL2, SUM
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] sr1_q, sr1_d;
  logic [10:0] sr2_q, sr2_d;
  logic [15:0] a1_q, a1_d;
  logic [15:0] a2_q, a2_d;
  logic [15:0] wa1_q, wa1_d;
  logic [15:0] wa2_q, wa2_d;
  logic [15:0] spole_q, spole_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic [15:0] mul_a;
  logic [10:0] mul_sr;
  logic [15:0] mul_w;
  logic [16:0] s17;

  // Float multiply of a Q14 coefficient by an 11-bit float sample.
  function automatic logic [15:0] fmult(
    input logic [15:0] an,
    input logic [10:0] sr
  );
    logic [12:0] mag;
    logic [3:0]  aexp;
    logic [5:0]  amant;
    logic [4:0]  wexp;
    logic [12:0] p;
    logic [7:0]  wm;
    logic [15:0] wmag;
    logic        ws;
    mag = 13'((an[15] ? (16'd0 - an) : an) >> 2);
    aexp = 4'd0;
    for (int i = 0; i < 13; i++)
      if (mag[i]) aexp = 4'(i + 1);
    if (mag == 13'd0) amant = 6'd32;
    else amant = 6'({mag, 6'b0} >> aexp);
    ws = sr[10] ^ an[15];
    wexp = {1'b0, sr[9:6]} + {1'b0, aexp};
    p = 13'(sr[5:0]) * 13'(amant) + 13'd48;
    wm = 8'(p >> 4);
    if (wexp > 5'd26)
      wmag = 16'((17'({wm, 7'b0}) << (wexp - 5'd26))
                 & 17'h07FFF);
    else
      wmag = 16'({wm, 7'b0} >> (5'd26 - wexp));
    return ws ? (16'd0 - wmag) : wmag;
  endfunction

  // Shared multiplier operands follow the active state.
  always_comb begin
    mul_a  = (state_q == MUL1) ? a1_q : a2_q;
    mul_sr = (state_q == MUL1) ? sr1_q : sr2_q;
    mul_w  = fmult(mul_a, mul_sr);
  end

  // Next-state, datapath and status logic.
  always_comb begin
    state_d = state_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    wa1_d   = wa1_q;
    wa2_d   = wa2_q;
    spole_d = spole_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    s17 = {wa1_q[15], wa1_q} + {wa2_q[15], wa2_q};
    unique case (state_q)
      IDLE: if (STB) begin
        sr2_d   = sr1_q;
        sr1_d   = SR0;
        a1_d    = A1;
        a2_d    = A2;
        state_d = MUL1;
      end
      MUL1: begin
        wa1_d   = mul_w;
        state_d = MUL2;
      end
      MUL2: begin
        wa2_d   = mul_w;
        state_d = SUM;
      end
      SUM: begin
`ifdef SR_POLE_SAT_EN
        if (s17[16] != s17[15])
          spole_d = s17[16] ? 16'h8000 : 16'h7FFF;
        else
          spole_d = s17[15:0];
`else
        spole_d = 16'(s17);
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (STB && state_q != IDLE) ovr_d = 1'b1;
    busy_d = (state_d != IDLE) || (state_q == SUM);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sr1_q   <= SR_RST;
      sr2_q   <= SR_RST;
      a1_q    <= '0;
      a2_q    <= '0;
      wa1_q   <= '0;
      wa2_q   <= '0;
      spole_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      wa1_q   <= wa1_d;
      wa2_q   <= wa2_d;
      spole_q <= spole_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign SPOLE = spole_q;
  assign DONE  = done_q;
  assign BUSY  = busy_q;
  assign OVR   = ovr_q;

endmodule

// File: tb/tb_sr_pole_pred.sv
// tb_sr_pole_pred: directed vectors, expected SPOLE and DONE cycle
// queued by the driver and checked by a DONE-triggered monitor.
module tb_sr_pole_pred;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STB = 1'b0;
  logic [10:0] SR0 = 11'h020;
  logic [15:0] A1 = '0;
  logic [15:0] A2 = '0;
  logic [15:0] SPOLE;
  logic        DONE;
  logic        BUSY;
  logic        OVR;

  typedef struct {
    logic [15:0] sp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

`ifdef SR_POLE_SAT_EN
  localparam logic [15:0] POS_OV = 16'h7FFF;
  localparam logic [15:0] NEG_OV = 16'h8000;
`else
  localparam logic [15:0] POS_OV = 16'h8600;
  localparam logic [15:0] NEG_OV = 16'h7A00;
`endif

  sr_pole_pred dut (
    .CLK(CLK), .RESET(RESET), .STB(STB),
    .SR0(SR0), .A1(A1), .A2(A2),
    .SPOLE(SPOLE), .DONE(DONE),
    .BUSY(BUSY), .OVR(OVR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Monitor: every DONE must match the oldest expectation.
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(SPOLE), 32'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("spole", 32'(SPOLE), 32'(e.sp));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic run(input logic [10:0] s,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [15:0] e);
    exp_t x;
    SR0 = s; A1 = a; A2 = b; STB = 1'b1;
    x.sp = e;
    x.cyc = cyc + 4;
    q.push_back(x);
    @(negedge CLK);
    STB = 1'b0;
    idle(3);
  endtask

  initial begin
    exp_t x;
    int   w;
    @(negedge CLK);
    do_reset();
    chk("rst_spole", 32'(SPOLE), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_ovr", 32'(OVR), 32'h0);

    run(11'h020, 16'h0000, 16'h0000, 16'h0000);

    do_reset();
    SR0 = 11'h020; A1 = 16'h4000; A2 = 16'h4000;
    STB = 1'b1;
    x.sp = 16'h0002; x.cyc = cyc + 4;
    q.push_back(x);
    @(negedge CLK);
    STB = 1'b0;
    chk("busy_mul1", 32'(BUSY), 32'h1);
    idle(3);

    do_reset();
    run(11'h1E0, 16'h4000, 16'h0000, 16'h0086);
    run(11'h020, 16'h0000, 16'hC000, 16'hFF7A);

    do_reset();
    run(11'h3A0, 16'h4000, 16'h4000, 16'h4301);
    run(11'h3A0, 16'h4000, 16'h4000, POS_OV);
    run(11'h3A0, 16'hC000, 16'hC000, NEG_OV);

    // STB held for three cycles: only the first is taken.
    SR0 = 11'h020; A1 = 16'h4000; A2 = 16'h0000;
    STB = 1'b1;
    x.sp = 16'h0003; x.cyc = cyc + 4;
    q.push_back(x);
    @(negedge CLK);
    SR0 = 11'h1E0; A1 = 16'hC000; A2 = 16'h4000;
    @(negedge CLK);
    @(negedge CLK);
    STB = 1'b0;
    chk("ovr_set", 32'(OVR), 32'h1);
    idle(1);
    run(11'h020, 16'h0000, 16'h4000, 16'h0001);
    chk("ovr_sticky", 32'(OVR), 32'h1);

    do_reset();
    chk("ovr_clr", 32'(OVR), 32'h0);
    run(11'h3A0, 16'h4000, 16'h4000, 16'h4301);

    // Abort during MUL2.
    SR0 = 11'h1E0; A1 = 16'h4000; A2 = 16'h4000;
    STB = 1'b1;
    @(negedge CLK);
    STB = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_spole", 32'(SPOLE), 32'h0);
    chk("abort_busy", 32'(BUSY), 32'h0);
    idle(4);
    chk("abort_done", 32'(DONE), 32'h0);
    run(11'h020, 16'h4000, 16'h4000, 16'h0002);

    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
